// File: rtl/mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_refill_arbiter
// Description : Round-robin merge of N bank memory ports onto one memory port,
//               with an owner FIFO steering in-order responses back to banks.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_refill_arbiter #(
    parameter int P_NUM_PORTS       = 4,
    parameter int P_MAX_OUTSTANDING = 4,
    parameter int P_REQ_W           = 175,
    parameter int P_RESP_W          = 145
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [P_NUM_PORTS*P_REQ_W-1:0]  bank_memreq_msg,
    input  logic [P_NUM_PORTS-1:0]          bank_memreq_val,
    output logic [P_NUM_PORTS-1:0]          bank_memreq_rdy,
    output logic [P_NUM_PORTS*P_RESP_W-1:0] bank_memresp_msg,
    output logic [P_NUM_PORTS-1:0]          bank_memresp_val,
    input  logic [P_NUM_PORTS-1:0]          bank_memresp_rdy,
    output logic [P_REQ_W-1:0]              memreq_msg,
    output logic                            memreq_val,
    input  logic                            memreq_rdy,
    input  logic [P_RESP_W-1:0]             memresp_msg,
    input  logic                            memresp_val,
    output logic                            memresp_rdy
);

    localparam int c_PORT_W  = $clog2(P_NUM_PORTS);
    localparam int c_FIFO_AW = (P_MAX_OUTSTANDING > 1) ? $clog2(P_MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W   = $clog2(P_MAX_OUTSTANDING + 1);

    localparam logic [c_CNT_W-1:0]   c_MAX_CNT   = c_CNT_W'(P_MAX_OUTSTANDING);
    localparam logic [c_FIFO_AW-1:0] c_LAST_IDX  = c_FIFO_AW'(P_MAX_OUTSTANDING - 1);
    localparam logic [c_PORT_W-1:0]  c_LAST_PORT = c_PORT_W'(P_NUM_PORTS - 1);
    localparam logic [c_PORT_W:0]    c_NUM_PORTS = (c_PORT_W + 1)'(P_NUM_PORTS);

    logic [c_PORT_W-1:0]  ptr_q,   ptr_d;
    logic [c_FIFO_AW-1:0] head_q,  head_d;
    logic [c_FIFO_AW-1:0] tail_q,  tail_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [c_PORT_W-1:0]  owner_q [P_MAX_OUTSTANDING];

    logic [c_PORT_W-1:0]  w_grant;
    logic                 w_any_val;
    logic                 w_can_issue;
    logic                 w_nonempty;
    logic [c_PORT_W-1:0]  w_head_owner;
    logic                 w_req_fire;
    logic                 w_resp_fire;

    // Rotating priority scan starting at ptr_q, wrapping modulo the port count.
    always_comb begin : p_grant
        logic [c_PORT_W:0] v_idx;
        w_grant   = '0;
        w_any_val = 1'b0;
        v_idx     = '0;
        for (int i = 0; i < P_NUM_PORTS; i++) begin
            v_idx = {1'b0, ptr_q} + (c_PORT_W + 1)'(i);
            if (v_idx >= c_NUM_PORTS) begin
                v_idx = v_idx - c_NUM_PORTS;
            end
            if (!w_any_val && bank_memreq_val[v_idx[c_PORT_W-1:0]]) begin
                w_any_val = 1'b1;
                w_grant   = v_idx[c_PORT_W-1:0];
            end
        end
    end

    // Outputs are gated with reset so every val/rdy is low while it is asserted.
    assign w_can_issue  = reset && (count_q < c_MAX_CNT);
    assign w_nonempty   = reset && (count_q != '0);
    assign w_head_owner = owner_q[head_q];

    assign memreq_val   = w_can_issue && w_any_val;
    assign memreq_msg   = bank_memreq_msg[w_grant*P_REQ_W +: P_REQ_W];
    assign w_req_fire   = memreq_val && memreq_rdy;

    assign memresp_rdy  = w_nonempty && bank_memresp_rdy[w_head_owner];
    assign w_resp_fire  = memresp_val && memresp_rdy;

    assign bank_memresp_msg = {P_NUM_PORTS{memresp_msg}};

    always_comb begin
        bank_memreq_rdy  = '0;
        bank_memresp_val = '0;
        if (w_can_issue && memreq_rdy && w_any_val) begin
            bank_memreq_rdy[w_grant] = 1'b1;
        end
        if (memresp_val && w_nonempty) begin
            bank_memresp_val[w_head_owner] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_req_fire) begin
            ptr_d  = (w_grant == c_LAST_PORT) ? '0 : w_grant + 1'b1;
            tail_d = (tail_q == c_LAST_IDX) ? '0 : tail_q + 1'b1;
        end
        if (w_resp_fire) begin
            head_d = (head_q == c_LAST_IDX) ? '0 : head_q + 1'b1;
        end
        unique case ({w_req_fire, w_resp_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < P_MAX_OUTSTANDING; i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (w_req_fire) begin
                owner_q[tail_q] <= w_grant;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_refill_arbiter
// Description : Directed and randomized bench for mem_refill_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_refill_arbiter;

    localparam int N      = 4;
    localparam int DEPTH  = 4;
    localparam int REQ_W  = 175;
    localparam int RESP_W = 145;
    localparam int NUM_TXN = 500;

    logic                  clk;
    logic                  reset;
    logic [N*REQ_W-1:0]    bank_memreq_msg;
    logic [N-1:0]          bank_memreq_val;
    logic [N-1:0]          bank_memreq_rdy;
    logic [N*RESP_W-1:0]   bank_memresp_msg;
    logic [N-1:0]          bank_memresp_val;
    logic [N-1:0]          bank_memresp_rdy;
    logic [REQ_W-1:0]      memreq_msg;
    logic                  memreq_val;
    logic                  memreq_rdy;
    logic [RESP_W-1:0]     memresp_msg;
    logic                  memresp_val;
    logic                  memresp_rdy;

    int passed = 0;
    int total  = 0;

    mem_refill_arbiter #(
        .P_NUM_PORTS       (N),
        .P_MAX_OUTSTANDING (DEPTH),
        .P_REQ_W           (REQ_W),
        .P_RESP_W          (RESP_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bank_memreq_msg  (bank_memreq_msg),
        .bank_memreq_val  (bank_memreq_val),
        .bank_memreq_rdy  (bank_memreq_rdy),
        .bank_memresp_msg (bank_memresp_msg),
        .bank_memresp_val (bank_memresp_val),
        .bank_memresp_rdy (bank_memresp_rdy),
        .memreq_msg       (memreq_msg),
        .memreq_val       (memreq_val),
        .memreq_rdy       (memreq_rdy),
        .memresp_msg      (memresp_msg),
        .memresp_val      (memresp_val),
        .memresp_rdy      (memresp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bank_memreq_msg  = '0;
        bank_memreq_val  = '0;
        bank_memresp_rdy = '0;
        memreq_rdy       = 1'b0;
        memresp_msg      = '0;
        memresp_val      = 1'b0;
    endtask

    function automatic logic [RESP_W-1:0] resp_of(input logic [REQ_W-1:0] r);
        return r[RESP_W-1:0] ^ {RESP_W{1'b1}};
    endfunction

    function automatic logic [REQ_W-1:0] mk_req(input int bank, input int seq);
        logic [191:0] raw;
        logic [REQ_W-1:0] m;
        raw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        m = raw[REQ_W-1:0];
        m[15:0]  = 16'(seq);
        m[18:16] = 3'(bank);
        return m;
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        clear_inputs();
        bank_memreq_val  = 4'hF;
        memreq_rdy       = 1'b1;
        memresp_val      = 1'b1;
        bank_memresp_rdy = 4'hF;
        #2;
        total++; if (memreq_val !== 1'b0) $display("FAIL reset_memreq_val: got %b want 0", memreq_val); else passed++;
        total++; if (bank_memreq_rdy !== 4'b0000) $display("FAIL reset_bank_memreq_rdy: got %b want 0000", bank_memreq_rdy); else passed++;
        total++; if (bank_memresp_val !== 4'b0000) $display("FAIL reset_bank_memresp_val: got %b want 0000", bank_memresp_val); else passed++;
        total++; if (memresp_rdy !== 1'b0) $display("FAIL reset_memresp_rdy: got %b want 0", memresp_rdy); else passed++;
        clear_inputs();
        tick();
        reset = 1'b1;
        #1;
        total++; if (memreq_val !== 1'b0) $display("FAIL post_reset_idle_memreq_val: got %b want 0", memreq_val); else passed++;
    endtask

    task automatic test_single;
        logic [REQ_W-1:0]  m;
        logic [RESP_W-1:0] r;
        m = mk_req(2, 0);
        m[63:32] = 32'h0000_1000;
        r = '0;
        r[127:0] = {4{32'hdeadbeef}};
        clear_inputs();
        bank_memreq_msg[2*REQ_W +: REQ_W] = m;
        bank_memreq_val = 4'b0100;
        memreq_rdy      = 1'b1;
        #1;
        total++; if (memreq_val !== 1'b1) $display("FAIL single_memreq_val: got %b want 1", memreq_val); else passed++;
        total++; if (bank_memreq_rdy !== 4'b0100) $display("FAIL single_bank_rdy: got %b want 0100", bank_memreq_rdy); else passed++;
        total++; if (memreq_msg !== m) $display("FAIL single_memreq_msg: got %h want %h", memreq_msg, m); else passed++;
        tick();
        clear_inputs();
        memresp_val      = 1'b1;
        memresp_msg      = r;
        bank_memresp_rdy = 4'hF;
        #1;
        total++; if (bank_memresp_val !== 4'b0100) $display("FAIL single_resp_val: got %b want 0100", bank_memresp_val); else passed++;
        total++; if (memresp_rdy !== 1'b1) $display("FAIL single_memresp_rdy: got %b want 1", memresp_rdy); else passed++;
        total++; if (bank_memresp_msg[2*RESP_W +: RESP_W] !== r) $display("FAIL single_resp_msg: got %h want %h", bank_memresp_msg[2*RESP_W +: RESP_W], r); else passed++;
        tick();
        total++; if (memresp_rdy !== 1'b0) $display("FAIL single_drained_rdy: got %b want 0", memresp_rdy); else passed++;
        total++; if (bank_memresp_val !== 4'b0000) $display("FAIL single_drained_val: got %b want 0000", bank_memresp_val); else passed++;
        clear_inputs();
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp_oh;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int b = 0; b < N; b++) bank_memreq_msg[b*REQ_W +: REQ_W] = mk_req(b, 100 + b);
        bank_memreq_val = 4'hF;
        memreq_rdy      = 1'b1;
        for (int k = 0; k < N; k++) begin
            #1;
            exp_oh = '0;
            exp_oh[k] = 1'b1;
            total++; if (bank_memreq_rdy !== exp_oh) $display("FAIL rr_grant_%0d: got %b want %b", k, bank_memreq_rdy, exp_oh); else passed++;
            tick();
        end
        #1;
        total++; if (memreq_val !== 1'b0) $display("FAIL rr_stall_when_full: got %b want 0", memreq_val); else passed++;
        total++; if (bank_memreq_rdy !== 4'b0000) $display("FAIL rr_stall_rdy: got %b want 0000", bank_memreq_rdy); else passed++;
    endtask

    task automatic test_full_fifo;
        memresp_val      = 1'b1;
        memresp_msg      = 145'h1234;
        bank_memresp_rdy = 4'hF;
        #1;
        total++; if (memresp_rdy !== 1'b1) $display("FAIL full_pop_rdy: got %b want 1", memresp_rdy); else passed++;
        total++; if (bank_memresp_val !== 4'b0001) $display("FAIL full_pop_owner: got %b want 0001", bank_memresp_val); else passed++;
        total++; if (memreq_val !== 1'b0) $display("FAIL full_no_bypass: got %b want 0", memreq_val); else passed++;
        tick();
        memresp_val = 1'b0;
        #1;
        total++; if (memreq_val !== 1'b1) $display("FAIL full_next_issue_val: got %b want 1", memreq_val); else passed++;
        total++; if (bank_memreq_rdy !== 4'b0001) $display("FAIL full_next_issue_grant: got %b want 0001", bank_memreq_rdy); else passed++;
        tick();
        total++; if (memreq_val !== 1'b0) $display("FAIL full_refilled: got %b want 0", memreq_val); else passed++;
    endtask

    task automatic test_backpressure;
        memresp_val      = 1'b1;
        bank_memresp_rdy = 4'b1101;
        #1;
        total++; if (memresp_rdy !== 1'b0) $display("FAIL bp_memresp_rdy: got %b want 0", memresp_rdy); else passed++;
        total++; if (bank_memresp_val !== 4'b0010) $display("FAIL bp_owner_val: got %b want 0010", bank_memresp_val); else passed++;
        tick();
        total++; if (memresp_rdy !== 1'b0) $display("FAIL bp_hold_rdy: got %b want 0", memresp_rdy); else passed++;
        total++; if (memreq_val !== 1'b0) $display("FAIL bp_count_held: got %b want 0", memreq_val); else passed++;
        bank_memresp_rdy = 4'hF;
        #1;
        total++; if (memresp_rdy !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", memresp_rdy); else passed++;
        tick();
        bank_memresp_rdy = 4'h0;
        bank_memreq_val  = 4'h0;
        #1;
        total++; if (bank_memresp_val !== 4'b0100) $display("FAIL bp_next_owner: got %b want 0100", bank_memresp_val); else passed++;
        memresp_val = 1'b0;
    endtask

    task automatic test_async_reset;
        bank_memreq_val  = 4'hF;
        memreq_rdy       = 1'b1;
        memresp_val      = 1'b1;
        bank_memresp_rdy = 4'hF;
        #1;
        total++; if (memreq_val !== 1'b1) $display("FAIL areset_pre_val: got %b want 1", memreq_val); else passed++;
        reset = 1'b0;
        #1;
        total++; if (memreq_val !== 1'b0) $display("FAIL areset_memreq_val: got %b want 0", memreq_val); else passed++;
        total++; if (bank_memreq_rdy !== 4'b0000) $display("FAIL areset_bank_rdy: got %b want 0000", bank_memreq_rdy); else passed++;
        total++; if (bank_memresp_val !== 4'b0000) $display("FAIL areset_resp_val: got %b want 0000", bank_memresp_val); else passed++;
        total++; if (memresp_rdy !== 1'b0) $display("FAIL areset_memresp_rdy: got %b want 0", memresp_rdy); else passed++;
        tick();
        clear_inputs();
        memresp_val      = 1'b1;
        bank_memresp_rdy = 4'hF;
        reset = 1'b1;
        #1;
        total++; if (memresp_rdy !== 1'b0) $display("FAIL areset_stray_rdy: got %b want 0", memresp_rdy); else passed++;
        total++; if (bank_memresp_val !== 4'b0000) $display("FAIL areset_stray_val: got %b want 0000", bank_memresp_val); else passed++;
        tick();
        total++; if (memresp_rdy !== 1'b0) $display("FAIL areset_stray_rdy2: got %b want 0", memresp_rdy); else passed++;
        memresp_val     = 1'b0;
        bank_memreq_val = 4'b1001;
        memreq_rdy      = 1'b1;
        #1;
        total++; if (bank_memreq_rdy !== 4'b0001) $display("FAIL areset_ptr_zero: got %b want 0001", bank_memreq_rdy); else passed++;
        clear_inputs();
        tick();
    endtask

    task automatic test_random;
        logic [REQ_W-1:0]  cur [N];
        logic              vq [N];
        int                issued [N];
        int                recv [N];
        logic [RESP_W-1:0] expq [N][$];
        logic [REQ_W-1:0]  memq [$];
        int                mown [$];
        int                mptr;
        int                rx_total;
        int                cyc;
        int                g;
        int                h;
        int                idx;
        logic              any;
        logic              exp_val;
        logic              req_fire;
        logic              resp_fire;
        logic [N-1:0]      exp_oh;
        logic [N-1:0]      exp_rv;
        logic              exp_rr;

        mptr = 0;
        rx_total = 0;
        cyc = 0;
        for (int b = 0; b < N; b++) begin
            cur[b] = '0; vq[b] = 1'b0; issued[b] = 0; recv[b] = 0;
        end
        clear_inputs();
        while (rx_total < NUM_TXN && cyc < 20000) begin
            for (int b = 0; b < N; b++) begin
                if (!vq[b] && issued[b] < NUM_TXN / N && $urandom_range(0, 1) == 1) begin
                    vq[b]  = 1'b1;
                    cur[b] = mk_req(b, issued[b]);
                end
                bank_memreq_val[b] = vq[b];
                bank_memreq_msg[b*REQ_W +: REQ_W] = cur[b];
            end
            memreq_rdy       = ($urandom_range(0, 3) != 0);
            bank_memresp_rdy = 4'($urandom);
            if (memq.size() > 0 && $urandom_range(0, 1) == 1) begin
                memresp_val = 1'b1;
                memresp_msg = resp_of(memq[0]);
            end else begin
                memresp_val = 1'b0;
                memresp_msg = '0;
            end
            #1;
            any = 1'b0;
            g = 0;
            for (int i = 0; i < N; i++) begin
                idx = (mptr + i) % N;
                if (!any && vq[idx]) begin
                    any = 1'b1;
                    g = idx;
                end
            end
            exp_val  = (mown.size() < DEPTH) && any;
            req_fire = exp_val && memreq_rdy;
            exp_oh = '0;
            if (req_fire) exp_oh[g] = 1'b1;
            total++; if (memreq_val !== exp_val) $display("FAIL rand_memreq_val cyc %0d: got %b want %b", cyc, memreq_val, exp_val); else passed++;
            total++; if (bank_memreq_rdy !== exp_oh) $display("FAIL rand_bank_rdy cyc %0d: got %b want %b", cyc, bank_memreq_rdy, exp_oh); else passed++;
            if (exp_val) begin
                total++; if (memreq_msg !== cur[g]) $display("FAIL rand_memreq_msg cyc %0d: got %h want %h", cyc, memreq_msg, cur[g]); else passed++;
            end
            h = (mown.size() > 0) ? mown[0] : 0;
            exp_rv = '0;
            if (memresp_val && mown.size() > 0) exp_rv[h] = 1'b1;
            exp_rr = (mown.size() > 0) && bank_memresp_rdy[h];
            resp_fire = memresp_val && exp_rr;
            total++; if (bank_memresp_val !== exp_rv) $display("FAIL rand_resp_val cyc %0d: got %b want %b", cyc, bank_memresp_val, exp_rv); else passed++;
            total++; if (memresp_rdy !== exp_rr) $display("FAIL rand_memresp_rdy cyc %0d: got %b want %b", cyc, memresp_rdy, exp_rr); else passed++;
            if (resp_fire) begin
                total++; if (bank_memresp_msg[h*RESP_W +: RESP_W] !== expq[h][0]) $display("FAIL rand_resp_msg bank %0d: got %h want %h", h, bank_memresp_msg[h*RESP_W +: RESP_W], expq[h][0]); else passed++;
            end
            tick();
            if (req_fire) begin
                mown.push_back(g);
                memq.push_back(cur[g]);
                expq[g].push_back(resp_of(cur[g]));
                vq[g] = 1'b0;
                issued[g]++;
                mptr = (g + 1) % N;
            end
            if (resp_fire) begin
                void'(mown.pop_front());
                void'(memq.pop_front());
                void'(expq[h].pop_front());
                recv[h]++;
                rx_total++;
            end
            cyc++;
        end
        clear_inputs();
        total++; if (rx_total != NUM_TXN) $display("FAIL rand_completion: got %0d responses want %0d", rx_total, NUM_TXN); else passed++;
        for (int b = 0; b < N; b++) begin
            total++; if (recv[b] != NUM_TXN / N) $display("FAIL rand_bank_%0d_count: got %0d want %0d", b, recv[b], NUM_TXN / N); else passed++;
        end
        #1;
        total++; if (memresp_rdy !== 1'b0) $display("FAIL rand_final_empty: got %b want 0", memresp_rdy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_fifo();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Sits directly downstream of the blocking cache banks' refill/evict memory ports, on the 16B memory side.
- Merges p_num_ports independent mem_req_16B_t streams onto one main-memory request port using round-robin arbitration.
- Routes in-order mem_resp_16B_t responses back to the issuing bank using an internal owner FIFO.
- Used to compose the four-banked data cache so all banks share one memory port.

Parameters:
- p_num_ports, 4: number of cache-bank memory ports. Legal values 2 to 8.
- p_max_outstanding, 4: depth of the owner FIFO, i.e. the maximum number of in-flight memory requests. Must be a power of 2, at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- bank_memreq_msg  input  p_num_ports x mem_req_16B_t (175b each)  request from each bank.
- bank_memreq_val  input  p_num_ports  request valid, one bit per bank.
- bank_memreq_rdy  output  p_num_ports  request accepted, one bit per bank.
- bank_memresp_msg  output  p_num_ports x mem_resp_16B_t (145b each)  response to each bank.
- bank_memresp_val  output  p_num_ports  response valid, one bit per bank.
- bank_memresp_rdy  input  p_num_ports  bank can accept a response.
- memreq_msg  output  mem_req_16B_t  request to main memory.
- memreq_val  output  1  memory request valid.
- memreq_rdy  input  1  memory accepts the request.
- memresp_msg  input  mem_resp_16B_t  response from main memory.
- memresp_val  input  1  memory response valid.
- memresp_rdy  output  1  arbiter accepts the response.

Behaviour:
- Reset (reset==0, asynchronous):
  - owner FIFO empty: head=tail=0, count=0.
  - round-robin priority pointer = 0.
  - all *_val and *_rdy outputs = 0 while reset is asserted.
  - Releasing reset mid-transaction discards all in-flight ownership. Responses that arrive before any new request is issued see an empty FIFO and are back-pressured (memresp_rdy=0).
- Request path (combinational, zero latency):
  - can_issue = (count < p_max_outstanding).
  - Grant goes to the first bank with val=1, searching from the pointer upward mod p_num_ports.
  - memreq_val = can_issue AND any bank_memreq_val.
  - memreq_msg = granted bank's msg, passed unmodified (opaque field untouched).
  - bank_memreq_rdy[g] = can_issue AND memreq_rdy, for the granted bank g only; all other rdy bits = 0.
  - On request fire (memreq_val AND memreq_rdy): push g into the FIFO at tail, tail++ (wrap), pointer <= (g+1) mod p_num_ports.
  - With no fire, the pointer holds.
  - A full FIFO blocks issue even if a pop happens the same cycle. No bypass, for timing.
- Response path (combinational, zero latency):
  - Memory returns responses in request order.
  - h = FIFO[head].
  - bank_memresp_val[h] = memresp_val AND (count>0); all other val bits = 0.
  - bank_memresp_msg for every port = memresp_msg (broadcast); only the val bit qualifies it.
  - memresp_rdy = (count>0) AND bank_memresp_rdy[h].
  - On response fire: head++ (wrap).
- Count update:
  - count += push − pop.
  - A simultaneous push and pop leaves count unchanged; both pointers advance.
  - count never exceeds p_max_outstanding and never goes below 0.
- Write requests also push an owner entry, because memory returns a write ack.
- No request or response combinationally depends on its own rdy→val path, so there is no combinational loop. A val is never withdrawn by this block once it is asserted, unless the FIFO drains.
- Line trace: the granted port index (or '.'), count, and the head owner.

Test Plan:
1. Single bank: bank 2 issues a read to addr 0x1000; memory returns data 0xdeadbeef... → memreq fires in the same cycle; the response appears only on bank_memresp_val[2], with count 1→0.
2. All 4 banks assert val continuously with memreq_rdy=1 → grants in order 0,1,2,3,0,... Issue stalls after 4 grants until a response fires.
3. Full FIFO (count=4) with a pop and a new request in the same cycle → no grant that cycle; the grant happens in the next cycle; count goes 4→3→4.
4. Out-of-phase bank backpressure: head owner is bank 1 with bank_memresp_rdy[1]=0 and memresp_val=1 → memresp_rdy=0 and count holds. The response is delivered in the cycle bank 1 raises rdy.
5. Reset asserted asynchronously with 3 requests outstanding → all vals/rdys drop immediately. After release, count=0, the pointer is 0, and a stray memresp_val sees memresp_rdy=0.
6. Random val/rdy on all interfaces with 500 mixed reads and writes → every bank receives exactly its own responses in issue order, and no FIFO overflow or underflow occurs.
